// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR datapath: sequencer states, default sizing, address helper.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package fir_pkg;

  typedef enum logic [1:0] {
    STARTUP,
    IDLE,
    RUN,
    DRAIN
  } fir_state_t;

  localparam int DEF_FILTER_LENGTH = 16;
  localparam int DEF_DSP_LATENCY   = 4;
  localparam int DEF_START_DELAY   = 7;

  // Widest delay-line address any instance may use; callers cast down to their own ADDR_W.
  localparam int ADDR_MAX_W = 16;
  typedef logic [ADDR_MAX_W-1:0] fir_addr_t;

  // (a - b) mod len for a, b < len. One extra bit catches the borrow, so the
  // wrap is exact for lengths that are not a power of two.
  function automatic fir_addr_t wrap_sub(input fir_addr_t a, input fir_addr_t b,
                                         input fir_addr_t len);
    logic [ADDR_MAX_W:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    if (diff[ADDR_MAX_W]) begin
      diff = diff + {1'b0, len};
    end
    return diff[ADDR_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/fir_mac_sequencer.sv
// Sequences one DSP58 MAC through all taps of a circular-delay-line FIR, one input sample at a time.
// Latency: accept at edge A -> taps in cycles A+1..A+FILTER_LENGTH -> out_valid in cycle A+FILTER_LENGTH+DSP_LATENCY.
// Backpressure: in_ready only in IDLE; in_valid elsewhere is held off by the source, never dropped.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter  int FILTER_LENGTH = DEF_FILTER_LENGTH,  // >= 2
  parameter  int DSP_LATENCY   = DEF_DSP_LATENCY,    // >= 1
  parameter  int START_DELAY   = DEF_START_DELAY,    // >= 1
  localparam int ADDR_W        = $clog2(FILTER_LENGTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] coef_addr,
  output logic [ADDR_W-1:0] samp_addr,
  output logic              dsp_ce,
  output logic              acc_load,
  output logic              out_valid,
  output logic              warm
);

  // Counter widths; a 1-bit minimum keeps degenerate latencies legal.
  localparam int DRN_W = (DSP_LATENCY > 1) ? $clog2(DSP_LATENCY) : 1;
  localparam int STU_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

  localparam logic [ADDR_W-1:0] LAST_TAP   = ADDR_W'(FILTER_LENGTH - 1);
  localparam logic [DRN_W-1:0]  LAST_DRAIN = DRN_W'(DSP_LATENCY - 1);
  localparam logic [STU_W-1:0]  LAST_START = STU_W'(START_DELAY - 1);

  fir_state_t        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] newest;
  logic [ADDR_W-1:0] tap;
  logic [ADDR_W-1:0] tap_nxt;
  logic [ADDR_W-1:0] samp_cnt;
  logic [DRN_W-1:0]  drain_cnt;
  logic [STU_W-1:0]  start_cnt;

  assign tap_nxt = tap + 1'b1;

  // The sample is written in the accept cycle itself, so the write strobe follows in_valid directly.
  assign wr_en   = (state == IDLE) && in_valid;
  assign wr_addr = wr_ptr;

  // Sequencer FSM; every tap/strobe output is registered alongside the state that implies it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= STARTUP;
      wr_ptr    <= '0;
      newest    <= '0;
      tap       <= '0;
      samp_cnt  <= '0;
      drain_cnt <= '0;
      start_cnt <= '0;
      in_ready  <= 1'b0;
      coef_addr <= '0;
      samp_addr <= '0;
      dsp_ce    <= 1'b0;
      acc_load  <= 1'b0;
      out_valid <= 1'b0;
      warm      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        STARTUP: begin
          if (start_cnt == LAST_START) begin
            state    <= IDLE;
            in_ready <= 1'b1;
          end else begin
            start_cnt <= start_cnt + 1'b1;
          end
        end

        IDLE: begin
          if (in_valid) begin
            state     <= RUN;
            in_ready  <= 1'b0;
            newest    <= wr_ptr;
            tap       <= '0;
            wr_ptr    <= (wr_ptr == LAST_TAP) ? '0 : wr_ptr + 1'b1;
            // Tap 0 reads the slot being written now, and starts a fresh sum.
            dsp_ce    <= 1'b1;
            acc_load  <= 1'b1;
            coef_addr <= '0;
            samp_addr <= wr_ptr;
            // Saturates once the delay line holds a full window of real samples.
            if (samp_cnt == LAST_TAP) begin
              warm <= 1'b1;
            end else begin
              samp_cnt <= samp_cnt + 1'b1;
            end
          end
        end

        RUN: begin
          acc_load <= 1'b0;
          if (tap == LAST_TAP) begin
            state     <= DRAIN;
            drain_cnt <= '0;
            dsp_ce    <= 1'b0;
            coef_addr <= '0;
            samp_addr <= '0;
            // With a single-cycle DSP the first drain cycle is already the result cycle.
            out_valid <= (LAST_DRAIN == '0);
          end else begin
            tap       <= tap_nxt;
            coef_addr <= tap_nxt;
            samp_addr <= ADDR_W'(wrap_sub(fir_addr_t'(newest), fir_addr_t'(tap_nxt),
                                          fir_addr_t'(FILTER_LENGTH)));
          end
        end

        DRAIN: begin
          if (drain_cnt == LAST_DRAIN) begin
            state    <= IDLE;
            in_ready <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
            out_valid <= ((drain_cnt + 1'b1) == LAST_DRAIN);
          end
        end

        default: begin
          state <= STARTUP;
        end
      endcase
    end
  end

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Control sequencer for the time-multiplexed FIR filter built on a single DSP58 MAC. It accepts one input sample at a time, writes it into the circular sample delay line, and steps the DSP58 through all FILTER_LENGTH tap products. It accounts for the DSP58 pipeline latency and strobes `out_valid` when the accumulated result is at the DSP output. It replaces free-running delay counters with an explicit handshake and state machine.

## Interface
- FILTER_LENGTH, 16, number of taps; ≥2; need not be a power of two
- DSP_LATENCY, 4, cycles from a tap issued (`dsp_ce`) to its product/accumulation at the DSP58 output; ≥1
- START_DELAY, 7, cycles after reset release before the first sample is accepted (DSP/BRAM settle)
- ADDR_W, $clog2(FILTER_LENGTH), derived; not overridden
- clk  input  1  single clock; all logic on the rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input sample offered
- in_ready  output  1  sequencer can accept a sample this cycle
- wr_en  output  1  write the current input sample into the delay line at `wr_addr`
- wr_addr  output  ADDR_W  delay-line write address (newest sample slot)
- coef_addr  output  ADDR_W  coefficient ROM address of the tap being issued
- samp_addr  output  ADDR_W  delay-line read address of the tap being issued
- dsp_ce  output  1  DSP58 issue enable; one tap per asserted cycle
- acc_load  output  1  with `dsp_ce`: load the product, ignoring the accumulator (first tap)
- out_valid  output  1  single-cycle strobe: DSP58 output holds a complete filter result
- warm  output  1  high once FILTER_LENGTH samples have been accepted since reset (delay line full)

## Operation
- States: STARTUP, IDLE, RUN, DRAIN.
- STARTUP: entered on reset. Counts START_DELAY cycles, then moves to IDLE. All strobes stay 0.
- IDLE: `in_ready`=1. On `in_valid & in_ready`:
  - `wr_en`=1 and `wr_addr`=wr_ptr in the same cycle (combinational from state and `in_valid`).
  - Next state is RUN with tap=0 and newest=wr_ptr.
  - wr_ptr advances by 1 and wraps FILTER_LENGTH-1 → 0.
- RUN: one tap per cycle, tap k = 0..FILTER_LENGTH-1.
  - `dsp_ce`=1, `coef_addr`=k.
  - `samp_addr`=(newest − k) mod FILTER_LENGTH, with explicit wrap-around for non-power-of-two lengths.
  - `acc_load`=1 only when k=0.
  - After k=FILTER_LENGTH-1, go to DRAIN with the drain counter at 0.
- DRAIN: counts DSP_LATENCY cycles.
  - `out_valid`=1 on the last DRAIN cycle (count = DSP_LATENCY-1).
  - Next state is IDLE.
- `in_ready`=0 in every state except IDLE. `in_valid` outside IDLE is held off (backpressure) and is never dropped.
- warm: a saturating sample counter increments on each accept. `warm` goes high on the cycle after the FILTER_LENGTH-th accept and stays high until reset.
- Arithmetic: all counters are unsigned. Tap and drain counters are sized to hold FILTER_LENGTH-1 and DSP_LATENCY-1. The address subtraction uses ADDR_W+1 bits before the wrap.
- Reset (any time, including mid-RUN or mid-DRAIN), asynchronously:
  - state=STARTUP; wr_ptr, tap, drain, startup and sample counters = 0.
  - All outputs 0, including `in_ready`, `warm` and every address.
  - A partially issued filter sum is abandoned; no `out_valid` is produced for it.

## Timing
- After reset release, `in_ready` is 0 for START_DELAY rising edges and rises at edge START_DELAY.
- Accept at edge A (`in_valid & in_ready` sampled high):
  - `wr_en` is high in the cycle ending at A.
  - Taps are issued in cycles A+1 .. A+FILTER_LENGTH.
  - `out_valid` is high in cycle A+FILTER_LENGTH+DSP_LATENCY.
  - `in_ready` is high again from cycle A+FILTER_LENGTH+DSP_LATENCY+1.
- Throughput: one sample per FILTER_LENGTH+DSP_LATENCY+1 cycles when `in_valid` is held high.
- If `in_valid` is asserted in the same cycle the state returns to IDLE, the sample is accepted that cycle.

## Structure
- Shared package `fir_pkg`:
  - state enum (STARTUP, IDLE, RUN, DRAIN);
  - default FILTER_LENGTH, DSP_LATENCY, START_DELAY constants;
  - a `wrap_sub` address function, also used by the delay-line RAM wrapper.
- Single module, no sub-module. The counters are small and all gated by state.

## Test plan
- Reset release, FILTER_LENGTH=16, DSP_LATENCY=4, START_DELAY=7 → `in_ready` 0 for 7 edges, 1 from edge 7; all other outputs 0 throughout.
- Single sample accepted at edge A, wr_ptr=0 → `wr_en`/`wr_addr`=0 at A. `dsp_ce` for exactly 16 cycles with `coef_addr` 0..15 and `samp_addr` 0,15,14..1. `acc_load` only on the first tap. One `out_valid` at A+20. `in_ready` back at A+21.
- `in_valid` held high for 20 samples → accepts spaced 21 cycles apart. wr_ptr wraps 15→0 on the 17th accept. `warm` rises after the 16th accept.
- `in_valid` pulsed during RUN and during DRAIN → no accept, no `wr_en`; the sample is taken at the first IDLE cycle.
- Reset asserted at tap 9 of RUN → all outputs 0 immediately. No `out_valid` for that sample. Full STARTUP of 7 cycles before `in_ready`, with wr_ptr and `warm` cleared.
- FILTER_LENGTH=5, DSP_LATENCY=1 → accept with newest=1 gives `samp_addr` 1,0,4,3,2. `out_valid` at A+6.
